// File: rtl/stopwatch_ctrl_if.sv
// Control bus between the stopwatch controller and the downstream BCD display counter.
interface stopwatch_ctrl_if;
  logic       en;
  logic       pause;
  logic       clr;
  logic [1:0] state_o;
  logic       ending;

  modport master (output en, output pause, output clr, output state_o, input ending);
  modport slave  (input en, input pause, input clr, input state_o, output ending);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key synchronise/debounce, run/pause/idle FSM and count-rate tick divider.
// Optional auto-stop on the counter's ending flag when STOPWATCH_AUTO_STOP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              key_start_n,
  input  logic              key_clr_n,
  stopwatch_ctrl_if.master  bus
);

  localparam int unsigned DIV   = CLK_FREQ / TICK_HZ;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index 0 = start key, index 1 = clear key.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [1:0]      armed;
  logic [1:0]      settle;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;

  state_t          state;
  logic [DIV_W-1:0] div;
  logic            tick;
  logic            stop;
  logic            s;
  logic            c;

  // A key only becomes armed once a released level has been seen after reset,
  // so a key held through reset cannot produce a press event.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      db        <= 2'b11;
      db_d      <= 2'b11;
      armed     <= 2'b00;
      settle    <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1  <= {key_clr_n, key_start_n};
      sync2  <= sync1;
      db_d   <= db;
      settle <= {settle[0], 1'b1};
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] != db[k]) begin
          if (db_cnt[k] == DB_W'(DB_CYCLES - 1)) begin
            db[k]     <= sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
        if (settle[1] && sync2[k]) begin
          armed[k] <= 1'b1;
        end
      end
    end
  end

  assign press = db_d & ~db & armed;
  assign s     = press[0];
  assign c     = press[1];
  assign tick  = (state == RUN) && (div == DIV_W'(DIV - 1));

`ifdef STOPWATCH_AUTO_STOP_EN
  assign stop = (state == RUN) && bus.ending;
`else
  logic unused_ending;
  assign unused_ending = bus.ending;
  assign stop          = 1'b0;
`endif

  // Clear beats every other event; the tick divider only advances in RUN so pause keeps phase.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      bus.en    <= 1'b0;
      bus.clr   <= 1'b0;
      bus.pause <= 1'b1;
    end else begin
      bus.en  <= 1'b0;
      bus.clr <= 1'b0;
      if (c) begin
        state     <= IDLE;
        div       <= '0;
        bus.en    <= 1'b1;
        bus.clr   <= 1'b1;
        bus.pause <= 1'b0;
      end else begin
        if (state == RUN) begin
          div <= tick ? '0 : div + 1'b1;
        end
        case (state)
          IDLE: begin
            if (s) begin
              state     <= RUN;
              bus.pause <= 1'b0;
            end else begin
              bus.pause <= 1'b1;
            end
          end
          RUN: begin
            bus.en <= tick && !stop;
            if (stop) begin
              state     <= DONE;
              bus.pause <= 1'b1;
            end else if (s) begin
              state     <= PAUSED;
              bus.pause <= 1'b1;
            end else begin
              bus.pause <= 1'b0;
            end
          end
          PAUSED: begin
            if (s) begin
              state     <= RUN;
              bus.pause <= 1'b0;
            end else begin
              bus.pause <= 1'b1;
            end
          end
          default: begin
            bus.pause <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (DIV=10, DB_CYCLES=4).
module tb_stopwatch_ctrl;

  logic clk;
  logic rst;
  logic key_start_n;
  logic key_clr_n;
  int   n_checks;
  int   n_fail;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_FREQ (100),
    .TICK_HZ  (10),
    .DB_CYCLES(4)
  ) dut (
    .CLK        (clk),
    .rst        (rst),
    .key_start_n(key_start_n),
    .key_clr_n  (key_clr_n),
    .bus        (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_start_n = 1'b1;
    key_clr_n = 1'b1;
    sw_if.ending = 1'b0;
    step();
    step();
    n_checks++;
    if (sw_if.en !== 1'b0 || sw_if.clr !== 1'b0 || sw_if.pause !== 1'b1 || sw_if.state_o !== 2'd0) begin
      $display("FAIL reset_values en=%b clr=%b pause=%b state=%0d expected en=0 clr=0 pause=1 state=0",
               sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
      n_fail++;
    end
    rst = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step();
      n_checks++;
      if (sw_if.en !== 1'b0 || sw_if.clr !== 1'b0 || sw_if.pause !== 1'b1 || sw_if.state_o !== 2'd0) begin
        $display("FAIL idle cyc=%0d en=%b clr=%b pause=%b state=%0d expected en=0 clr=0 pause=1 state=0",
                 i, sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
        n_fail++;
      end
    end
  endtask

  task automatic test_start();
    logic exp_en;
    key_start_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i >= 6) begin
        n_checks++;
        if (sw_if.state_o !== ((i == 7) ? 2'd1 : 2'd0)) begin
          $display("FAIL start_latency edge=%0d state=%0d expected %0d", i, sw_if.state_o, (i == 7) ? 1 : 0);
          n_fail++;
        end
      end
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 13) key_start_n = 1'b1;
      exp_en = ((k % 10) == 0);
      n_checks++;
      if (sw_if.en !== exp_en || sw_if.clr !== 1'b0 || sw_if.pause !== 1'b0 || sw_if.state_o !== 2'd1) begin
        $display("FAIL run_tick k=%0d en=%b clr=%b pause=%b state=%0d expected en=%b clr=0 pause=0 state=1",
                 k, sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o, exp_en);
        n_fail++;
      end
    end
  endtask

  task automatic test_glitch();
    key_start_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 2) key_start_n = 1'b1;
      n_checks++;
      if (sw_if.state_o !== 2'd1 || sw_if.en !== (i == 10)) begin
        $display("FAIL glitch i=%0d state=%0d en=%b expected state=1 en=%b", i, sw_if.state_o, sw_if.en, i == 10);
        n_fail++;
      end
    end
  endtask

  task automatic test_pause_resume();
    logic exp_en;
    key_start_n = 1'b0;
    for (int i = 1; i <= 37; i++) begin
      step();
      if (i == 10) key_start_n = 1'b1;
      n_checks++;
      if (i < 7) begin
        if (sw_if.state_o !== 2'd1 || sw_if.en !== 1'b0) begin
          $display("FAIL pause_entry i=%0d state=%0d en=%b expected state=1 en=0", i, sw_if.state_o, sw_if.en);
          n_fail++;
        end
      end else if (sw_if.state_o !== 2'd2 || sw_if.en !== 1'b0 || sw_if.pause !== 1'b1) begin
        $display("FAIL paused i=%0d state=%0d en=%b pause=%b expected state=2 en=0 pause=1",
                 i, sw_if.state_o, sw_if.en, sw_if.pause);
        n_fail++;
      end
    end
    key_start_n = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 10) key_start_n = 1'b1;
      n_checks++;
      if (j < 7) begin
        if (sw_if.state_o !== 2'd2 || sw_if.en !== 1'b0) begin
          $display("FAIL resume_wait j=%0d state=%0d en=%b expected state=2 en=0", j, sw_if.state_o, sw_if.en);
          n_fail++;
        end
      end else begin
        exp_en = (j == 10) || (j == 20);
        if (sw_if.state_o !== 2'd1 || sw_if.pause !== 1'b0 || sw_if.en !== exp_en) begin
          $display("FAIL resume_phase j=%0d state=%0d pause=%b en=%b expected state=1 pause=0 en=%b",
                   j, sw_if.state_o, sw_if.pause, sw_if.en, exp_en);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    key_start_n = 1'b0;
    key_clr_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) begin
        key_start_n = 1'b1;
        key_clr_n = 1'b1;
      end
      n_checks++;
      if (i < 7) begin
        if (sw_if.state_o !== 2'd1 || sw_if.en !== 1'b0 || sw_if.clr !== 1'b0) begin
          $display("FAIL simul_wait i=%0d state=%0d en=%b clr=%b expected state=1 en=0 clr=0",
                   i, sw_if.state_o, sw_if.en, sw_if.clr);
          n_fail++;
        end
      end else if (i == 7) begin
        if (sw_if.en !== 1'b1 || sw_if.clr !== 1'b1 || sw_if.pause !== 1'b0 || sw_if.state_o !== 2'd0) begin
          $display("FAIL simul_clear en=%b clr=%b pause=%b state=%0d expected en=1 clr=1 pause=0 state=0",
                   sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
          n_fail++;
        end
      end else if (sw_if.en !== 1'b0 || sw_if.clr !== 1'b0 || sw_if.pause !== 1'b1 || sw_if.state_o !== 2'd0) begin
        $display("FAIL simul_after i=%0d en=%b clr=%b pause=%b state=%0d expected en=0 clr=0 pause=1 state=0",
                 i, sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
        n_fail++;
      end
    end
  endtask

  task automatic test_clear_on_tick();
    key_start_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 10) begin
        key_start_n = 1'b1;
        key_clr_n = 1'b0;
      end
      if (i == 17) key_clr_n = 1'b1;
      if (i == 7 || (i > 10 && i < 17)) begin
        n_checks++;
        if (sw_if.state_o !== 2'd1 || sw_if.en !== 1'b0) begin
          $display("FAIL tick_clear_run i=%0d state=%0d en=%b expected state=1 en=0", i, sw_if.state_o, sw_if.en);
          n_fail++;
        end
      end else if (i == 17) begin
        n_checks++;
        if (sw_if.en !== 1'b1 || sw_if.clr !== 1'b1 || sw_if.pause !== 1'b0 || sw_if.state_o !== 2'd0) begin
          $display("FAIL tick_clear_cycle en=%b clr=%b pause=%b state=%0d expected en=1 clr=1 pause=0 state=0",
                   sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
          n_fail++;
        end
      end else if (i > 17) begin
        n_checks++;
        if (sw_if.en !== 1'b0 || sw_if.clr !== 1'b0 || sw_if.pause !== 1'b1 || sw_if.state_o !== 2'd0) begin
          $display("FAIL tick_clear_after i=%0d en=%b clr=%b pause=%b state=%0d expected en=0 clr=0 pause=1 state=0",
                   i, sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
          n_fail++;
        end
      end
    end
  endtask

`ifdef STOPWATCH_AUTO_STOP_EN
  task automatic test_auto_stop();
    key_start_n = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      step();
      if (i == 10) key_start_n = 1'b1;
      if (i == 12) sw_if.ending = 1'b1;
      if (i == 13) sw_if.ending = 1'b0;
      if (i == 15) key_start_n = 1'b0;
      if (i == 25) key_start_n = 1'b1;
      if (i == 40) key_clr_n = 1'b0;
      if (i == 50) key_clr_n = 1'b1;
      if (i >= 13 && i < 47) begin
        n_checks++;
        if (sw_if.state_o !== 2'd3 || sw_if.en !== 1'b0 || sw_if.pause !== 1'b1) begin
          $display("FAIL done_hold i=%0d state=%0d en=%b pause=%b expected state=3 en=0 pause=1",
                   i, sw_if.state_o, sw_if.en, sw_if.pause);
          n_fail++;
        end
      end else if (i == 47) begin
        n_checks++;
        if (sw_if.en !== 1'b1 || sw_if.clr !== 1'b1 || sw_if.pause !== 1'b0 || sw_if.state_o !== 2'd0) begin
          $display("FAIL done_clear en=%b clr=%b pause=%b state=%0d expected en=1 clr=1 pause=0 state=0",
                   sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
          n_fail++;
        end
      end else if (i == 48) begin
        n_checks++;
        if (sw_if.en !== 1'b0 || sw_if.pause !== 1'b1 || sw_if.state_o !== 2'd0) begin
          $display("FAIL done_after en=%b pause=%b state=%0d expected en=0 pause=1 state=0",
                   sw_if.en, sw_if.pause, sw_if.state_o);
          n_fail++;
        end
      end
    end
  endtask
`else
  task automatic test_ending_ignored();
    key_start_n = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 10) key_start_n = 1'b1;
      if (i == 12) sw_if.ending = 1'b1;
      if (i == 13) sw_if.ending = 1'b0;
      if (i >= 13) begin
        n_checks++;
        if (sw_if.state_o !== 2'd1 || sw_if.pause !== 1'b0 || sw_if.en !== (i == 17 || i == 27)) begin
          $display("FAIL ending_ignored i=%0d state=%0d pause=%b en=%b expected state=1 pause=0 en=%b",
                   i, sw_if.state_o, sw_if.pause, sw_if.en, i == 17);
          n_fail++;
        end
      end
    end
  endtask
`endif

  task automatic test_reset_held();
    key_start_n = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (sw_if.en !== 1'b0 || sw_if.clr !== 1'b0 || sw_if.pause !== 1'b1 || sw_if.state_o !== 2'd0) begin
      $display("FAIL midrun_reset en=%b clr=%b pause=%b state=%0d expected en=0 clr=0 pause=1 state=0",
               sw_if.en, sw_if.clr, sw_if.pause, sw_if.state_o);
      n_fail++;
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      n_checks++;
      if (sw_if.state_o !== 2'd0 || sw_if.en !== 1'b0 || sw_if.pause !== 1'b1) begin
        $display("FAIL held_key i=%0d state=%0d en=%b pause=%b expected state=0 en=0 pause=1",
                 i, sw_if.state_o, sw_if.en, sw_if.pause);
        n_fail++;
      end
    end
    key_start_n = 1'b1;
    for (int i = 1; i <= 10; i++) step();
    key_start_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i >= 6) begin
        n_checks++;
        if (sw_if.state_o !== ((i == 7) ? 2'd1 : 2'd0)) begin
          $display("FAIL repress edge=%0d state=%0d expected %0d", i, sw_if.state_o, (i == 7) ? 1 : 0);
          n_fail++;
        end
      end
    end
    key_start_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_start();
    test_glitch();
    test_pause_resume();
    test_simultaneous();
    test_clear_on_tick();
`ifdef STOPWATCH_AUTO_STOP_EN
    test_auto_stop();
`else
    test_ending_ignored();
`endif
    test_reset_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
